// File: rtl/wb_mem_slave_pkg.sv
// Shared types for the Wishbone memory slave: request record, FSM states, lane count.
package wb_pkg;

  localparam int WB_AW = 16;
  localparam int WB_DW = 32;
  localparam int SEL_W = WB_DW / 8;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             err;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_state_e;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone B4 bus bundle between an initiator and the memory slave.
interface wb_mem_slave_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [AW-1:0]   adr_i;
  logic [DW/8-1:0] sel_i;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic            ack_o;
  logic            err_o;
  logic            stall_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, stall_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_mem_slave_ram.sv
// Single-port RAM with per-byte write enables and a registered, resettable read port.
module wb_bytemask_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en && we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register doubles as the bus data output, so it alone is reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            rdata <= '0;
    else if (en && !we)   rdata <= mem[addr];
  end
endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 memory slave: wait states, out-of-range error, classic or pipelined protocol.
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | counting down inserted wait states
// RESP  | request is committed/read on the closing edge of this cycle
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int PIPELINED   = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_mem_slave_if.slave bus
);
  localparam int          RAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_req_t req_in;
  wb_req_t rsp_req;
  logic    rsp_fire;
  logic    ack_q;
  logic    err_q;
  logic    unused_adr;

  always_comb begin
    req_in.we  = bus.we_i;
    req_in.adr = bus.adr_i;
    req_in.dat = bus.dat_i;
    req_in.sel = bus.sel_i;
    req_in.err = ({1'b0, bus.adr_i} >= DEPTH_W);
  end

  if (PIPELINED != 0) begin : g_pipe
    logic                 stall_q;
    logic                 accept;
    logic [WAIT_STATES:0] valid_q;
    wb_req_t              pipe_q [WAIT_STATES+1];

    assign accept      = bus.cyc_i & bus.stb_i & ~stall_q;
    assign bus.stall_o = stall_q;
    // A response due while cyc_i is already low is dropped.
    assign rsp_fire    = valid_q[WAIT_STATES] & bus.cyc_i;
    assign rsp_req     = pipe_q[WAIT_STATES];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= 1'b1;
      else       stall_q <= 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
      end else if (!bus.cyc_i) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= accept;
        for (int i = 1; i <= WAIT_STATES; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      pipe_q[0] <= req_in;
      for (int i = 1; i <= WAIT_STATES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end else begin : g_classic
    wb_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    wb_req_t    req_q;

    assign bus.stall_o = 1'b0;
    assign rsp_req     = req_q;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      rsp_fire = 1'b0;
      case (state_q)
        IDLE: if (bus.cyc_i && bus.stb_i) begin
          accept  = 1'b1;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          if (!bus.cyc_i)          state_d = IDLE;
          else if (cnt_q == 4'd0)  state_d = RESP;
          else                     cnt_d   = cnt_q - 4'd1;
        end
        RESP: begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept) req_q <= req_in;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= rsp_fire & ~rsp_req.err;
      err_q <= rsp_fire & rsp_req.err;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  // Upper address bits only feed the range check.
  assign unused_adr = ^rsp_req.adr;

  wb_bytemask_ram #(.DW(DW), .DEPTH(DEPTH), .AW(RAW)) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (rsp_fire & ~rsp_req.err),
    .we    (rsp_req.we),
    .sel   (rsp_req.sel),
    .addr  (rsp_req.adr[RAW-1:0]),
    .wdata (rsp_req.dat),
    .rdata (bus.dat_o)
  );
endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave in classic and pipelined configurations.
module tb_wb_mem_slave;
  import wb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_mem_slave_if #(.AW(16), .DW(32)) bc2 ();
  wb_mem_slave_if #(.AW(16), .DW(32)) bc3 ();
  wb_mem_slave_if #(.AW(16), .DW(32)) bp1 ();
  wb_mem_slave_if #(.AW(16), .DW(32)) bp3 ();

  wb_mem_slave #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(2), .PIPELINED(0))
    u_c2 (.clk_i(clk_i), .rst_i(rst_i), .bus(bc2.slave));
  wb_mem_slave #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(3), .PIPELINED(0))
    u_c3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bc3.slave));
  wb_mem_slave #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(1), .PIPELINED(1))
    u_p1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bp1.slave));
  wb_mem_slave #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(3), .PIPELINED(1))
    u_p3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bp3.slave));

  task automatic drive_c(input int d, input logic cyc, input logic stb, input logic we,
                         input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      bc2.cyc_i = cyc; bc2.stb_i = stb; bc2.we_i = we;
      bc2.adr_i = adr; bc2.dat_i = dat; bc2.sel_i = sel;
    end else begin
      bc3.cyc_i = cyc; bc3.stb_i = stb; bc3.we_i = we;
      bc3.adr_i = adr; bc3.dat_i = dat; bc3.sel_i = sel;
    end
  endtask

  task automatic drive_p(input int d, input logic cyc, input logic stb, input logic we,
                         input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      bp1.cyc_i = cyc; bp1.stb_i = stb; bp1.we_i = we;
      bp1.adr_i = adr; bp1.dat_i = dat; bp1.sel_i = sel;
    end else begin
      bp3.cyc_i = cyc; bp3.stb_i = stb; bp3.we_i = we;
      bp3.adr_i = adr; bp3.dat_i = dat; bp3.sel_i = sel;
    end
  endtask

  task automatic get_c(input int d, output logic a, output logic e, output logic [31:0] q);
    if (d == 0) begin a = bc2.ack_o; e = bc2.err_o; q = bc2.dat_o; end
    else        begin a = bc3.ack_o; e = bc3.err_o; q = bc3.dat_o; end
  endtask

  task automatic get_p(input int d, output logic a, output logic e, output logic [31:0] q);
    if (d == 0) begin a = bp1.ack_o; e = bp1.err_o; q = bp1.dat_o; end
    else        begin a = bp3.ack_o; e = bp3.err_o; q = bp3.dat_o; end
  endtask

  // Classic transfer: stb held until the response is seen; lat counts edges after accept.
  task automatic c_xfer(input int d, input logic we, input logic [15:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output logic ack, output logic err,
                        output logic [31:0] rdat);
    logic a, e;
    logic [31:0] q;
    lat = -1; ack = 1'b0; err = 1'b0; rdat = '0;
    drive_c(d, 1'b1, 1'b1, we, adr, dat, sel);
    @(posedge clk_i); #1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      get_c(d, a, e, q);
      if (a || e) begin
        lat = n; ack = a; err = e; rdat = q;
        break;
      end
    end
    drive_c(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic p_xfer(input int d, input logic we, input logic [15:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output logic ack, output logic err,
                        output logic [31:0] rdat);
    logic a, e;
    logic [31:0] q;
    lat = -1; ack = 1'b0; err = 1'b0; rdat = '0;
    drive_p(d, 1'b1, 1'b1, we, adr, dat, sel);
    @(posedge clk_i); #1;
    drive_p(d, 1'b1, 1'b0, we, adr, dat, sel);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      get_p(d, a, e, q);
      if (a || e) begin
        lat = n; ack = a; err = e; rdat = q;
        break;
      end
    end
    drive_p(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      drive_c(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive_p(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (bc2.ack_o !== 1'b0 || bc2.err_o !== 1'b0) begin
      bad++; $display("FAIL rst_resp got ack=%b err=%b exp 0 0", bc2.ack_o, bc2.err_o);
    end
    total++; if (bc2.dat_o !== 32'h0) begin
      bad++; $display("FAIL rst_dat got=%h exp=0", bc2.dat_o);
    end
    total++; if (bp1.stall_o !== 1'b1) begin
      bad++; $display("FAIL rst_stall got=%b exp=1", bp1.stall_o);
    end
    total++; if (bc2.stall_o !== 1'b0) begin
      bad++; $display("FAIL classic_stall got=%b exp=0", bc2.stall_o);
    end
    rst_i = 1'b0;
    #1;
    total++; if (bp1.stall_o !== 1'b1) begin
      bad++; $display("FAIL stall_after_release got=%b exp=1", bp1.stall_o);
    end
    @(posedge clk_i); #1;
    total++; if (bp1.stall_o !== 1'b0 || bp3.stall_o !== 1'b0) begin
      bad++; $display("FAIL stall_cleared got=%b/%b exp=0/0", bp1.stall_o, bp3.stall_o);
    end
  endtask

  task automatic test_write_read();
    int lat; logic a, e; logic [31:0] q;
    c_xfer(0, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF, lat, a, e, q);
    total++; if (lat !== 3 || a !== 1'b1 || e !== 1'b0) begin
      bad++; $display("FAIL wr_lat got lat=%0d ack=%b err=%b exp 3 1 0", lat, a, e);
    end
    @(posedge clk_i); #1;
    total++; if (bc2.ack_o !== 1'b0) begin
      bad++; $display("FAIL ack_one_cycle got=%b exp=0", bc2.ack_o);
    end
    c_xfer(0, 1'b0, 16'd5, 32'h0, 4'hF, lat, a, e, q);
    total++; if (lat !== 3 || a !== 1'b1 || q !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_adr5 got lat=%0d ack=%b dat=%h exp 3 1 deadbeef", lat, a, q);
    end
    // stb without cyc must be ignored
    drive_c(0, 1'b0, 1'b1, 1'b1, 16'd5, 32'h0, 4'hF);
    a = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (bc2.ack_o || bc2.err_o) a = 1'b1;
    end
    drive_c(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    total++; if (a !== 1'b0) begin
      bad++; $display("FAIL stb_no_cyc got resp=%b exp=0", a);
    end
    c_xfer(0, 1'b0, 16'd5, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'hDEADBEEF) begin
      bad++; $display("FAIL stb_no_cyc_data got=%h exp=deadbeef", q);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic a, e; logic [31:0] q;
    c_xfer(0, 1'b1, 16'd9, 32'hAABBCCDD, 4'hF, lat, a, e, q);
    c_xfer(0, 1'b1, 16'd9, 32'h11223344, 4'b0101, lat, a, e, q);
    c_xfer(0, 1'b0, 16'd9, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'hAA22CC44) begin
      bad++; $display("FAIL byte_lanes got=%h exp=aa22cc44", q);
    end
    c_xfer(0, 1'b1, 16'd9, 32'h0, 4'h0, lat, a, e, q);
    total++; if (a !== 1'b1 || e !== 1'b0 || lat !== 3) begin
      bad++; $display("FAIL sel0_ack got ack=%b err=%b lat=%0d exp 1 0 3", a, e, lat);
    end
    c_xfer(0, 1'b0, 16'd9, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'hAA22CC44) begin
      bad++; $display("FAIL sel0_data got=%h exp=aa22cc44", q);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic a, e; logic [31:0] q;
    c_xfer(0, 1'b0, 16'd1024, 32'h0, 4'hF, lat, a, e, q);
    total++; if (e !== 1'b1 || a !== 1'b0 || lat !== 3) begin
      bad++; $display("FAIL oor_rd got err=%b ack=%b lat=%0d exp 1 0 3", e, a, lat);
    end
    total++; if (q !== 32'hAA22CC44) begin
      bad++; $display("FAIL oor_dat_hold got=%h exp=aa22cc44", q);
    end
    @(posedge clk_i); #1;
    total++; if (bc2.err_o !== 1'b0) begin
      bad++; $display("FAIL err_one_cycle got=%b exp=0", bc2.err_o);
    end
    c_xfer(0, 1'b1, 16'd0, 32'h12345678, 4'hF, lat, a, e, q);
    c_xfer(0, 1'b1, 16'd1024, 32'hFFFFFFFF, 4'hF, lat, a, e, q);
    total++; if (e !== 1'b1 || a !== 1'b0) begin
      bad++; $display("FAIL oor_wr got err=%b ack=%b exp 1 0", e, a);
    end
    c_xfer(0, 1'b0, 16'd0, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'h12345678) begin
      bad++; $display("FAIL oor_no_alias got=%h exp=12345678", q);
    end
    c_xfer(0, 1'b1, 16'd1023, 32'h3FF3FF00, 4'hF, lat, a, e, q);
    c_xfer(0, 1'b0, 16'd1023, 32'h0, 4'hF, lat, a, e, q);
    total++; if (a !== 1'b1 || e !== 1'b0 || q !== 32'h3FF3FF00) begin
      bad++; $display("FAIL last_word got ack=%b err=%b dat=%h exp 1 0 3ff3ff00", a, e, q);
    end
  endtask

  task automatic test_pipelined();
    logic a, e, exp_a; logic [31:0] q;
    for (int pass = 0; pass < 2; pass++) begin
      drive_p(0, 1'b1, 1'b1, (pass == 0), 16'd0, 32'hC0DE0000, 4'hF);
      for (int j = 0; j < 12; j++) begin
        @(posedge clk_i); #1;
        get_p(0, a, e, q);
        exp_a = (j >= 2 && j <= 9);
        total++; if (a !== exp_a || e !== 1'b0) begin
          bad++; $display("FAIL pipe_ack pass=%0d j=%0d got=%b exp=%b", pass, j, a, exp_a);
        end
        if (pass == 1) begin
          total++; if (bp1.stall_o !== 1'b0) begin
            bad++; $display("FAIL pipe_stall j=%0d got=%b exp=0", j, bp1.stall_o);
          end
          if (exp_a) begin
            total++; if (q !== 32'hC0DE0000 + 32'(j - 2)) begin
              bad++; $display("FAIL pipe_rd_data j=%0d got=%h exp=%h", j, q, 32'hC0DE0000 + 32'(j - 2));
            end
          end
        end
        if (j < 7) drive_p(0, 1'b1, 1'b1, (pass == 0), 16'(j + 1), 32'hC0DE0000 + 32'(j + 1), 4'hF);
        else       drive_p(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      end
      drive_p(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic a, e; logic [31:0] q;
    // write then read of the same word on consecutive edges
    drive_p(0, 1'b1, 1'b1, 1'b1, 16'd20, 32'h55AA55AA, 4'hF);
    @(posedge clk_i); #1;
    drive_p(0, 1'b1, 1'b1, 1'b0, 16'd20, 32'h0, 4'hF);
    @(posedge clk_i); #1;
    drive_p(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk_i); #1;
    total++; if (bp1.ack_o !== 1'b1) begin
      bad++; $display("FAIL raw_wr_ack got=%b exp=1", bp1.ack_o);
    end
    @(posedge clk_i); #1;
    total++; if (bp1.ack_o !== 1'b1 || bp1.dat_o !== 32'h55AA55AA) begin
      bad++; $display("FAIL raw_rd got ack=%b dat=%h exp 1 55aa55aa", bp1.ack_o, bp1.dat_o);
    end
    drive_p(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    p_xfer(0, 1'b0, 16'd2000, 32'h0, 4'hF, lat, a, e, q);
    total++; if (e !== 1'b1 || a !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL pipe_oor got err=%b ack=%b lat=%0d exp 1 0 2", e, a, lat);
    end
    // cyc falls during the cycle the response is due
    p_xfer(0, 1'b1, 16'd30, 32'h30303030, 4'hF, lat, a, e, q);
    drive_p(0, 1'b1, 1'b1, 1'b1, 16'd30, 32'hDEAD0030, 4'hF);
    @(posedge clk_i); #1;
    drive_p(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk_i); #1;
    drive_p(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    a = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (bp1.ack_o || bp1.err_o) a = 1'b1;
    end
    total++; if (a !== 1'b0) begin
      bad++; $display("FAIL late_cyc_drop got resp=%b exp=0", a);
    end
    p_xfer(0, 1'b0, 16'd30, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'h30303030) begin
      bad++; $display("FAIL late_cyc_drop_data got=%h exp=30303030", q);
    end
  endtask

  task automatic test_abort();
    int lat; logic a, e; logic [31:0] q;
    p_xfer(1, 1'b1, 16'd3, 32'h03030303, 4'hF, lat, a, e, q);
    total++; if (lat !== 4 || a !== 1'b1) begin
      bad++; $display("FAIL p3_lat got lat=%0d ack=%b exp 4 1", lat, a);
    end
    drive_p(1, 1'b1, 1'b1, 1'b1, 16'd3, 32'hFFFFFFFF, 4'hF);
    @(posedge clk_i); #1;
    drive_p(1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk_i); #1;
    drive_p(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    a = 1'b0;
    repeat (8) begin
      @(posedge clk_i); #1;
      if (bp3.ack_o || bp3.err_o) a = 1'b1;
    end
    total++; if (a !== 1'b0) begin
      bad++; $display("FAIL p_abort_resp got=%b exp=0", a);
    end
    p_xfer(1, 1'b0, 16'd3, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'h03030303) begin
      bad++; $display("FAIL p_abort_data got=%h exp=03030303", q);
    end

    c_xfer(1, 1'b1, 16'd3, 32'h03030303, 4'hF, lat, a, e, q);
    total++; if (lat !== 4 || a !== 1'b1) begin
      bad++; $display("FAIL c3_lat got lat=%0d ack=%b exp 4 1", lat, a);
    end
    drive_c(1, 1'b1, 1'b1, 1'b1, 16'd3, 32'hFFFFFFFF, 4'hF);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    drive_c(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    a = 1'b0;
    repeat (8) begin
      @(posedge clk_i); #1;
      if (bc3.ack_o || bc3.err_o) a = 1'b1;
    end
    total++; if (a !== 1'b0) begin
      bad++; $display("FAIL c_abort_resp got=%b exp=0", a);
    end
    c_xfer(1, 1'b0, 16'd3, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'h03030303) begin
      bad++; $display("FAIL c_abort_data got=%h exp=03030303", q);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic a, e; logic [31:0] q;
    c_xfer(0, 1'b1, 16'd7, 32'h13572468, 4'hF, lat, a, e, q);
    c_xfer(0, 1'b0, 16'd7, 32'h0, 4'hF, lat, a, e, q);
    drive_c(0, 1'b1, 1'b1, 1'b1, 16'd7, 32'hFFFF0000, 4'hF);
    @(posedge clk_i); #1;
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    total++; if (bc2.ack_o !== 1'b0 || bc2.err_o !== 1'b0 || bc2.dat_o !== 32'h0) begin
      bad++; $display("FAIL async_rst got ack=%b err=%b dat=%h exp 0 0 0", bc2.ack_o, bc2.err_o, bc2.dat_o);
    end
    drive_c(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    total++; if (u_c2.g_classic.state_q !== IDLE) begin
      bad++; $display("FAIL rst_fsm got=%0d exp=%0d", u_c2.g_classic.state_q, IDLE);
    end
    c_xfer(0, 1'b0, 16'd7, 32'h0, 4'hF, lat, a, e, q);
    total++; if (q !== 32'h13572468 || lat !== 3) begin
      bad++; $display("FAIL rst_no_write got=%h lat=%0d exp 13572468 3", q, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_pipelined();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Parametrised Wishbone B4 memory slave, the next generation of the team's Wishbone endpoint. It extends the bare cyc/stb/ack handshake with address, data, byte-select and write-enable lanes. It adds configurable wait states, an error response for out-of-range addresses, and a selectable classic or pipelined protocol mode. It sits behind the Wishbone interconnect as the on-chip scratch/ping-pong store for the SDRAM agent and DSP test benches.

## Interface
- AW, 16: address width, word-addressed.
- DW, 32: data width, multiple of 8.
- DEPTH, 1024: number of DW-bit words; DEPTH ≤ 2**AW.
- WAIT_STATES, 0: extra cycles inserted before each response, 0..15.
- PIPELINED, 0: 0 selects classic mode, 1 selects B4 pipelined mode.

- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  AW  word address.
- sel_i  in  DW/8  byte-lane enables.
- dat_i  in  DW  write data.
- dat_o  out  DW  read data, valid while ack_o = 1.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination (address ≥ DEPTH).
- stall_o  out  1  pipelined-mode back-pressure; tied 0 in classic mode.

## Operation
- Accept: a request is accepted on the edge where cyc_i & stb_i & ~stall_o hold and, in classic mode, the FSM is IDLE. adr/dat/sel/we are captured at the accept edge.
- Range check: adr ≥ DEPTH yields err_o instead of ack_o. No memory write occurs and dat_o is not updated.
- Writes: commit on the response edge. Only lanes with sel = 1 are written; sel = 0 on every lane is a legal write that writes nothing and still acks.
- Reads: memory is read on the response edge into dat_o. dat_o holds until the next read response.
- Classic FSM: IDLE → WAIT (counter loads WAIT_STATES−1) → RESP → IDLE.
  - With WAIT_STATES = 0, IDLE goes directly to RESP.
  - RESP lasts exactly one cycle with ack_o or err_o high.
  - Back-to-back requests therefore complete at most every WAIT_STATES+2 cycles.
- Classic abort: cyc_i low in WAIT returns to IDLE. No ack, no err, no write.
- Pipelined mode: requests flow through a (WAIT_STATES+1)-stage shift pipeline of {valid, we, adr, dat, sel, err}.
  - A new request can be accepted every cycle.
  - Responses return in order, one per accepted request.
  - stall_o is 0 except during the cycle after reset release, when it is 1.
- Pipelined abort: cyc_i low clears every valid bit. In-flight writes are discarded and no responses are issued for them.
- Ordering: read-after-write to the same address in pipelined mode returns the new data, because commit and read happen at the same stage in order.
- stb_i without cyc_i is ignored in both modes.

## Timing
- Reset values: ack_o = 0, err_o = 0, dat_o = 0, stall_o = 1 while rst_i is high, FSM = IDLE, pipeline valid bits = 0. Memory contents are not reset.
- Latency is measured from the accept edge k to the response edge: k + WAIT_STATES + 1 in both modes.
- ack_o and err_o are registered outputs, never combinational from the inputs, and are mutually exclusive.
- rst_i asserted mid-transfer clears all outputs asynchronously. No write from an in-flight request may occur after reset asserts.
- Pipelined mode, cyc_i falling in the same cycle a response is due: the response is suppressed. ack_o stays 0 on the following edge.

## Structure
- Package wb_pkg:
  - wb_req_t struct {we, adr, dat, sel, err}, parametrised via localparams derived from AW/DW.
  - wb_state_e enum {IDLE, WAIT, RESP}.
  - SEL_W = DW/8.
- Sub-module wb_bytemask_ram: DEPTH×DW synchronous single-port RAM with per-byte write enable and registered read.
- Both modes share wb_bytemask_ram. The top level holds the FSM, the wait counter, the pipeline and the range check.

## Test plan
- Classic, WAIT_STATES = 2: write 0xDEADBEEF to adr 5 with sel = 4'hF → ack_o exactly 3 cycles after accept. A subsequent read of adr 5 → dat_o = 0xDEADBEEF with ack_o.
- Byte lanes: write 0x11223344 with sel = 4'b0101 over a word holding 0xAABBCCDD → read returns 0xAA22CC44.
- Out of range, DEPTH = 1024: read adr 1024 → err_o high for one cycle, ack_o = 0, dat_o unchanged.
- Pipelined, WAIT_STATES = 1: 8 consecutive reads of adr 0..7 with stb held → 8 consecutive ack_o cycles starting 2 cycles after the first accept, data in order, stall_o = 0 throughout.
- Abort: pipelined write to adr 3, then cyc_i dropped 1 cycle later (WAIT_STATES = 3) → no ack_o, and adr 3 keeps its old value. Classic mode with the same stimulus gives the same result.
- Async reset mid-WAIT: assert rst_i between clock edges → ack_o, err_o and dat_o go to 0 immediately, FSM is in IDLE after release, and the target word is unmodified.
